// File: rtl/router_pkg.sv
// Shared flit/state types and default sizing for the router allocators.
package router_pkg;

  typedef enum logic [1:0] {
    HEAD      = 2'd0,
    BODY      = 2'd1,
    TAIL      = 2'd2,
    HEAD_TAIL = 2'd3
  } FLIT_TYPE_t;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } SA_STATE_t;

  localparam int NUM_INPUTS     = 5;
  localparam int TIMEOUT_CYCLES = 64;

  function automatic logic is_head(input FLIT_TYPE_t t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input FLIT_TYPE_t t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping from N-1 back to 0. Shared by the switch and VC allocators.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  // First pass finds the lowest requester overall (the wrap-around winner);
  // the second pass overrides it with the lowest requester at or above ptr.
  always_comb begin
    idx   = '0;
    grant = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) idx = IDX_W'(j);
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (IDX_W'(j) >= ptr)) idx = IDX_W'(j);
    end
    if (|req) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/switch_allocator.sv
// Packet-level round-robin switch allocator for one router output unit.
// Optional stalled-lock watchdog is built when SA_TIMEOUT_EN is defined.
import router_pkg::*;

module switch_allocator #(
  parameter int NUM_INPUTS     = router_pkg::NUM_INPUTS,
  parameter int IDX_W          = $clog2(NUM_INPUTS),
  parameter int TIMEOUT_CYCLES = router_pkg::TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic       [NUM_INPUTS-1:0]        i_switch_req,
  input  FLIT_TYPE_t [NUM_INPUTS-1:0]        i_flit_type,
  input  logic                               i_out_ready,
  output logic       [NUM_INPUTS-1:0]        o_switch_ack,
  output logic                               o_grant_valid,
  output logic       [IDX_W-1:0]             o_grant_idx,
  output logic                               o_timeout
);

  SA_STATE_t             state, next_state;
  logic [IDX_W-1:0]      rr_ptr, grant_idx, win_idx, next_ptr;
  logic [NUM_INPUTS-1:0] eligible, win_grant;
  logic                  transfer, tail_xfer, watchdog_fire;

  // Only packet heads may open a new lock.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eligible[i] = i_switch_req[i] && is_head(i_flit_type[i]);
    end
  end

  rr_arbiter #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign transfer  = (state == SA_LOCKED) && i_switch_req[grant_idx] && i_out_ready;
  assign tail_xfer = transfer && is_tail(i_flit_type[grant_idx]);
  assign next_ptr  = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SA_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state <= next_state;
      if ((state == SA_IDLE) && (|win_grant)) grant_idx <= win_idx;
      if ((state == SA_LOCKED) && (next_state == SA_IDLE)) rr_ptr <= next_ptr;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SA_IDLE:   if (|win_grant) next_state = SA_LOCKED;
      SA_LOCKED: if (tail_xfer || watchdog_fire) next_state = SA_IDLE;
      default:   next_state = SA_IDLE;
    endcase
  end

  // Ack is suppressed in the reset cycle so an aborted packet moves no flit.
  always_comb begin
    o_switch_ack = '0;
    if (transfer && !reset) o_switch_ack[grant_idx] = 1'b1;
  end

  assign o_grant_valid = (state == SA_LOCKED);
  assign o_grant_idx   = grant_idx;

`ifdef SA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall, timeout_q;

  // A stall is a ready cycle the holder leaves unused; fire as the count reaches TIMEOUT_CYCLES-1.
  assign stall         = (state == SA_LOCKED) && i_out_ready && !transfer;
  assign watchdog_fire = stall && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= watchdog_fire;
      if ((state != SA_LOCKED) || transfer || watchdog_fire) stall_cnt <= '0;
      else if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign watchdog_fire      = 1'b0;
  assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed, table-driven bench for switch_allocator plus hand-written stall/watchdog sequences.
module tb_switch_allocator;
  import router_pkg::*;

  localparam int N  = NUM_INPUTS;
  localparam int IW = $clog2(N);
`ifdef SA_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef FLIT_TYPE_t [N-1:0] ftv_t;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    ftv_t          ft;
    logic          rdy;
    logic [N-1:0]  ack;
    logic          valid;
    logic [IW-1:0] idx;
    logic          tmo;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  i_switch_req;
  ftv_t          i_flit_type;
  logic          i_out_ready;
  logic [N-1:0]  o_switch_ack;
  logic          o_grant_valid;
  logic [IW-1:0] o_grant_idx;
  logic          o_timeout;

  vec_t          vecs[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            vec_id = 0;
  logic [N-1:0]  last_ack;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk           (clk),
    .reset         (reset),
    .i_switch_req  (i_switch_req),
    .i_flit_type   (i_flit_type),
    .i_out_ready   (i_out_ready),
    .o_switch_ack  (o_switch_ack),
    .o_grant_valid (o_grant_valid),
    .o_grant_idx   (o_grant_idx),
    .o_timeout     (o_timeout)
  );

  function automatic ftv_t ftAll(input FLIT_TYPE_t t);
    ftv_t r;
    for (int i = 0; i < N; i++) r[i] = t;
    return r;
  endfunction

  function automatic ftv_t ft1(input int i, input FLIT_TYPE_t t);
    ftv_t r;
    r    = ftAll(HEAD);
    r[i] = t;
    return r;
  endfunction

  function automatic ftv_t ft2(input int i, input FLIT_TYPE_t t, input int j, input FLIT_TYPE_t u);
    ftv_t r;
    r    = ft1(i, t);
    r[j] = u;
    return r;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [N-1:0] req, input ftv_t ft,
                               input logic rdy, input logic [N-1:0] ack, input logic valid,
                               input logic [IW-1:0] idx, input logic tmo);
    vec_t v;
    v.rst = rst; v.req = req; v.ft = ft; v.rdy = rdy;
    v.ack = ack; v.valid = valid; v.idx = idx; v.tmo = tmo;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input int id, input logic [31:0] act,
                             input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", tag, id, act, exp);
    end
  endtask

  // Drive one vector just after a rising edge, then settle to the falling edge.
  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    i_switch_req = v.req;
    i_flit_type  = v.ft;
    i_out_ready  = v.rdy;
    @(negedge clk);
    last_ack = o_switch_ack;
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    n_vec++;
    checkOutput("switch_ack", vec_id, 32'(o_switch_ack), 32'(v.ack));
    checkOutput("grant_valid", vec_id, 32'(o_grant_valid), 32'(v.valid));
    if (v.valid) checkOutput("grant_idx", vec_id, 32'(o_grant_idx), 32'(v.idx));
    checkOutput("timeout", vec_id, 32'(o_timeout), 32'(v.tmo));
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[3];
    int flits;
    order = '{0, 1, 4};

    // Reset held with every input requesting: nothing granted or acked.
    vecs.push_back(mkv(1, '1, ftAll(HEAD_TAIL), 1, '0, 0, 0, 0));
    vecs.push_back(mkv(1, '1, ftAll(HEAD_TAIL), 1, '0, 0, 0, 0));
    // Input 2 sends HEAD, BODY, TAIL.
    vecs.push_back(mkv(0, 5'b00100, ft1(2, HEAD), 1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b00100, ft1(2, HEAD), 1, 5'b00100, 1, 2, 0));
    vecs.push_back(mkv(0, 5'b00100, ft1(2, BODY), 1, 5'b00100, 1, 2, 0));
    vecs.push_back(mkv(0, 5'b00100, ft1(2, TAIL), 1, 5'b00100, 1, 2, 0));
    vecs.push_back(mkv(0, '0,       ftAll(HEAD),  1, '0,       0, 0, 0));
    // rr_ptr is now 3, so input 4 beats input 1.
    vecs.push_back(mkv(0, 5'b10010, ftAll(HEAD_TAIL), 1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b10010, ftAll(HEAD_TAIL), 1, 5'b10000, 1, 4, 0));
    vecs.push_back(mkv(0, '0,       ftAll(HEAD),      1, '0,       0, 0, 0));
    vecs.push_back(mkv(1, '0,       ftAll(HEAD),      1, '0,       0, 0, 0));
    // Inputs 0, 1, 4 stream single-flit packets: one arbitration cycle per packet.
    for (int p = 0; p < 6; p++) begin
      vecs.push_back(mkv(0, 5'b10011, ftAll(HEAD_TAIL), 1, '0, 0, 0, 0));
      vecs.push_back(mkv(0, 5'b10011, ftAll(HEAD_TAIL), 1, N'(1) << order[p % 3], 1,
                         IW'(order[p % 3]), 0));
    end
    vecs.push_back(mkv(0, '0, ftAll(HEAD), 1, '0, 0, 0, 0));
    // A BODY-fronted requester is not eligible; input 3 wins and input 0 is ignored.
    vecs.push_back(mkv(0, 5'b01001, ft2(0, BODY, 3, HEAD),      1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b01001, ft2(0, BODY, 3, HEAD_TAIL), 1, 5'b01000, 1, 3, 0));
    vecs.push_back(mkv(0, '0,       ftAll(HEAD),                1, '0,       0, 0, 0));
    // Single requester re-granted after each tail.
    vecs.push_back(mkv(0, 5'b00001, ftAll(HEAD_TAIL), 1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b00001, ftAll(HEAD_TAIL), 1, 5'b00001, 1, 0, 0));
    vecs.push_back(mkv(0, 5'b00001, ftAll(HEAD_TAIL), 1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b00001, ftAll(HEAD_TAIL), 1, 5'b00001, 1, 0, 0));
    vecs.push_back(mkv(0, '0,       ftAll(HEAD),      1, '0,       0, 0, 0));
    // rr_ptr=1; input 0 locks, reset hits its BODY flit while input 1 waits.
    vecs.push_back(mkv(0, 5'b00001, ftAll(HEAD),      1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b00011, ftAll(HEAD),      1, 5'b00001, 1, 0, 0));
    vecs.push_back(mkv(1, 5'b00011, ft1(0, BODY),     1, '0,       1, 0, 0));
    vecs.push_back(mkv(0, 5'b00011, ftAll(HEAD),      1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b00011, ftAll(HEAD),      1, 5'b00001, 1, 0, 0));
    vecs.push_back(mkv(0, 5'b00011, ft1(0, TAIL),     1, 5'b00001, 1, 0, 0));
    vecs.push_back(mkv(0, 5'b00010, ftAll(HEAD),      1, '0,       0, 0, 0));
    vecs.push_back(mkv(0, 5'b00010, ft1(1, HEAD_TAIL), 1, 5'b00010, 1, 1, 0));
    vecs.push_back(mkv(0, '0,       ftAll(HEAD),      1, '0,       0, 0, 0));

    reset        = 1'b1;
    i_switch_req = '1;
    i_flit_type  = ftAll(HEAD_TAIL);
    i_out_ready  = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) runVec(vecs[k]);

    // Downstream back-pressure for 10 cycles mid-packet; input 3 requests meanwhile.
    flits = 0;
    runVec(mkv(0, 5'b00010, ft1(1, HEAD), 1, '0,       0, 0, 0));
    runVec(mkv(0, 5'b00010, ft1(1, HEAD), 1, 5'b00010, 1, 1, 0));
    flits += int'(last_ack[1]);
    for (int c = 0; c < 10; c++) begin
      runVec(mkv(0, 5'b01010, ft2(1, BODY, 3, HEAD), 0, '0, 1, 1, 0));
      flits += int'(last_ack[1]);
    end
    runVec(mkv(0, 5'b01010, ft2(1, BODY, 3, HEAD), 1, 5'b00010, 1, 1, 0));
    flits += int'(last_ack[1]);
    runVec(mkv(0, 5'b01010, ft2(1, TAIL, 3, HEAD), 1, 5'b00010, 1, 1, 0));
    flits += int'(last_ack[1]);
    n_vec++;
    checkOutput("flit_count", vec_id, 32'(flits), 32'd3);

    // Input 3 sends HEAD then goes silent with the output ready.
    runVec(mkv(0, 5'b01000, ft1(3, HEAD), 1, '0,       0, 0, 0));
    runVec(mkv(0, 5'b01000, ft1(3, HEAD), 1, 5'b01000, 1, 3, 0));
    for (int k = 1; k <= 70; k++) begin
      runVec(mkv(0, '0, ftAll(HEAD), 1, '0,
                 TMO_EN ? (k < TIMEOUT_CYCLES) : 1'b1, 3,
                 TMO_EN ? (k == TIMEOUT_CYCLES) : 1'b0));
    end
    if (!TMO_EN) runVec(mkv(0, 5'b01000, ft1(3, TAIL), 1, 5'b01000, 1, 3, 0));
    // Either way the lock on input 3 ended, so rr_ptr=4 and input 4 beats input 0.
    runVec(mkv(0, 5'b10001, ftAll(HEAD_TAIL), 1, '0,       0, 0, 0));
    runVec(mkv(0, 5'b10001, ftAll(HEAD_TAIL), 1, 5'b10000, 1, 4, 0));
    runVec(mkv(0, '0,       ftAll(HEAD),      1, '0,       0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
